fetch_unit: RTL and testbench

//  Instruction fetch stage of the RV32I core; feeds the decode stage.

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: PC, single-outstanding req/gnt/rvalid to imem, IR handshake to decode.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects raise a sticky trap instead of being aligned.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  , output logic      fetch_misaligned
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_TRAP  = 3'd5;

  logic [2:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_ir_pc;
  logic        r_ir_valid;

  logic [31:0] w_redir_pc;
  logic        w_trap_req;
  logic        w_outstanding;
  logic [2:0]  w_drain_exit;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misaligned;

  assign w_redir_pc       = redirect_pc;
  assign w_trap_req       = |redirect_pc[1:0];
  assign w_drain_exit     = r_misaligned ? S_TRAP : S_REQ;
  assign fetch_misaligned = r_misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_misaligned <= 1'b0;
    else if (redirect_valid)
      r_misaligned <= w_trap_req;
  end
`else
  assign w_redir_pc   = redirect_pc & 32'hFFFF_FFFC;
  assign w_trap_req   = 1'b0;
  assign w_drain_exit = S_REQ;
`endif

  // A request is still owed an rvalid after this edge if it is granted now,
  // or if we are already waiting and the data has not arrived yet.
  assign w_outstanding = ((r_state == S_REQ) && imem_gnt) ||
                         (((r_state == S_WAIT) || (r_state == S_DRAIN)) && !imem_rvalid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_ir       <= NOP_INSN;
      r_ir_pc    <= 32'h0000_0000;
      r_ir_valid <= 1'b0;
    end else if (redirect_valid) begin
      r_pc       <= w_redir_pc;
      r_ir       <= NOP_INSN;
      r_ir_valid <= 1'b0;
      if (w_outstanding)
        r_state <= S_DRAIN;
      else if (w_trap_req)
        r_state <= S_TRAP;
      else
        r_state <= S_REQ;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (imem_gnt)
            r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            r_ir       <= imem_rdata;
            r_ir_pc    <= r_pc;
            r_ir_valid <= 1'b1;
            r_pc       <= r_pc + 32'd4;
            r_state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (ir_ready) begin
            r_ir_valid <= 1'b0;
            r_state    <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid)
            r_state <= w_drain_exit;
        end
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req  = (r_state == S_REQ);
  assign imem_addr = r_pc;
  assign ir        = r_ir;
  assign ir_pc     = r_ir_pc;
  assign ir_valid  = r_ir_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: memory stub + transaction-level model compared every cycle.
// Build with FETCH_MISALIGN_TRAP_EN defined to also exercise the misalignment trap.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_misaligned(fetch_misaligned)
`endif
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // model: next fetch address, IR contents, one-in-flight bookkeeping
  logic [31:0] m_pc, m_ir, m_irpc;
  bit m_valid, m_outst, m_live, m_started, m_trap;

  // memory stub and stimulus knobs
  bit pend;
  int pend_cnt;
  int k_gnt = 100, k_rdy = 100, k_redir = 0, k_dly = 0;
  bit os_redir = 1'b0;
  logic [31:0] os_tgt;
  logic [31:0] grant_q[$];
  logic [31:0] held;
  int guard;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic bit m_req_exp();
    return m_started && !m_outst && !m_valid && !m_trap;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ir = NOP; m_irpc = 32'h0;
    m_valid = 0; m_outst = 0; m_live = 0; m_started = 0; m_trap = 0;
    pend = 0; pend_cnt = 0;
  endtask

  task automatic compare();
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_req_exp()});
    if (m_req_exp()) chk("imem_addr", imem_addr, m_pc);
    chk("ir_valid", {31'b0, ir_valid}, {31'b0, m_valid});
    chk("ir", ir, m_ir);
    chk("ir_pc", ir_pc, m_irpc);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("fetch_misaligned", {31'b0, fetch_misaligned}, {31'b0, m_trap});
`endif
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0 | ($urandom & 32'hF);
    else t = $urandom & 32'h0000_0FFF;
`ifdef FETCH_MISALIGN_TRAP_EN
    if ($urandom_range(3) != 0) t[1:0] = 2'b00;
`endif
    return t;
  endfunction

  // One clock: drive inputs for the coming edge, advance model, compare after the edge.
  task automatic cycle();
    logic [31:0] addr_now;
    logic [31:0] tgt;
    bit mis;
    addr_now       = imem_addr;
    imem_gnt       = imem_req && !pend && ($urandom_range(99) < k_gnt);
    imem_rvalid    = pend && (pend_cnt == 0);
    imem_rdata     = $urandom;
    ir_ready       = ($urandom_range(99) < k_rdy);
    if (os_redir) begin
      redirect_valid = 1'b1; redirect_pc = os_tgt; os_redir = 1'b0;
    end else begin
      redirect_valid = ($urandom_range(99) < k_redir);
      redirect_pc    = rand_target();
    end
    if (rst_n) begin
      if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        tgt = redirect_pc; mis = |redirect_pc[1:0];
`else
        tgt = {redirect_pc[31:2], 2'b00}; mis = 1'b0;
`endif
        m_pc = tgt; m_valid = 0; m_ir = NOP; m_trap = mis;
        if (imem_gnt) begin m_outst = 1; m_live = 0; end
        else if (imem_rvalid) m_outst = 0;
        else m_live = 0;
      end else begin
        if (imem_gnt) begin m_outst = 1; m_live = 1; end
        if (imem_rvalid && m_outst) begin
          m_outst = 0;
          if (m_live) begin
            m_ir = imem_rdata; m_irpc = m_pc; m_pc = m_pc + 32'd4; m_valid = 1;
          end
        end else if (m_valid && ir_ready) m_valid = 0;
      end
      m_started = 1;
      if (imem_rvalid) pend = 0;
      else if (pend) pend_cnt--;
      if (imem_gnt) begin
        pend = 1; pend_cnt = $urandom_range(k_dly); grant_q.push_back(addr_now);
      end
    end
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic wait_grants(input int n, input string name);
    guard = 0;
    while (grant_q.size() < n && guard < 60) begin cycle(); guard++; end
    chk(name, {31'b0, guard < 60}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_gnt = 0; imem_rvalid = 0; ir_ready = 0; redirect_valid = 0;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    compare();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; ir_ready = 0;
    redirect_valid = 0; redirect_pc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare();
    chk("reset_ir_literal", ir, 32'h0000_0013);
    chk("reset_req_literal", {31'b0, imem_req}, 32'd0);
    rst_n = 1'b1;

    // sequential fetches from reset
    grant_q.delete();
    wait_grants(3, "t1_timeout");
    if (grant_q.size() >= 3) begin
      chk("t1_addr0", grant_q[0], 32'h0);
      chk("t1_addr1", grant_q[1], 32'h4);
      chk("t1_addr2", grant_q[2], 32'h8);
    end

    // decode stall holds IR and blocks requests
    guard = 0;
    while (!ir_valid && guard < 60) begin cycle(); guard++; end
    chk("t2_timeout", {31'b0, guard < 60}, 32'd1);
    held = ir_pc;
    k_rdy = 0;
    repeat (5) begin
      cycle();
      chk("t2_hold_pc", ir_pc, held);
      chk("t2_no_req", {31'b0, imem_req}, 32'd0);
    end
    k_rdy = 100;
    grant_q.delete();
    wait_grants(1, "t2_timeout2");
    if (grant_q.size() >= 1) chk("t2_next_addr", grant_q[0], held + 32'd4);

    // redirect during WAIT
    k_dly = 2;
    guard = 0;
    while (!pend && guard < 60) begin cycle(); guard++; end
    chk("t3_timeout", {31'b0, guard < 60}, 32'd1);
    os_redir = 1; os_tgt = 32'h100;
    grant_q.delete();
    wait_grants(1, "t3_timeout2");
    if (grant_q.size() >= 1) chk("t3_addr", grant_q[0], 32'h100);

    // wrap at top of address space
    k_dly = 0;
    os_redir = 1; os_tgt = 32'hFFFF_FFFC;
    cycle();
    grant_q.delete();
    wait_grants(2, "t4_timeout");
    if (grant_q.size() >= 2) begin
      chk("t4_addr_top", grant_q[0], 32'hFFFF_FFFC);
      chk("t4_addr_wrap", grant_q[1], 32'h0000_0000);
    end

    // redirect while request ungranted
    k_gnt = 0;
    guard = 0;
    while (!imem_req && guard < 60) begin cycle(); guard++; end
    chk("t5_timeout", {31'b0, guard < 60}, 32'd1);
    os_redir = 1; os_tgt = 32'h300;
    cycle();
    chk("t5_addr_switch", imem_addr, 32'h300);
    chk("t5_req", {31'b0, imem_req}, 32'd1);
    k_gnt = 100;
    grant_q.delete();
    wait_grants(1, "t5_timeout2");
    if (grant_q.size() >= 1) chk("t5_granted", grant_q[0], 32'h300);

`ifdef FETCH_MISALIGN_TRAP_EN
    os_redir = 1; os_tgt = 32'h102;
    repeat (6) cycle();
    chk("t6_flag_set", {31'b0, fetch_misaligned}, 32'd1);
    chk("t6_no_req", {31'b0, imem_req}, 32'd0);
    os_redir = 1; os_tgt = 32'h200;
    grant_q.delete();
    wait_grants(1, "t6_timeout");
    chk("t6_flag_clr", {31'b0, fetch_misaligned}, 32'd0);
    if (grant_q.size() >= 1) chk("t6_addr", grant_q[0], 32'h200);
`endif

    // randomized traffic with a mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        k_gnt = $urandom_range(100, 30); k_rdy = $urandom_range(100, 20);
        k_redir = $urandom_range(15); k_dly = $urandom_range(3);
      end
      if (i == 1500) do_reset();
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
